dht11_responder: RTL and testbench

//  DHT11 sensor emulator: the responding end of the single-wire DHT11 protocol.
//  - Detects the host start pulse on dhtio and answers with the response preamble.
//  - Then sends a 40-bit frame: humidity, temperature, checksum.
//  - Used in self-test builds and benches in place of a physical sensor.
//  - Connects to the same dhtio net as dht11_controller.

---
 rtl/dht11_responder.sv | 197 +++++++++++++++++++
 tb/tb_dht11_responder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_responder.sv
// dht11_responder: DHT11 sensor emulator, the responding end of the single-wire bus.
// It answers a host start pulse with the response preamble, then sends a 40-bit
// frame {humidity, temperature, checksum} MSB first. The bus is open-drain, so
// dhtio is only ever driven to 0 or released.
// Optional build macro DHT11_CKSUM_ERR_EN adds i_corrupt_cksum. When it is set, the
// transmitted checksum is inverted in bit 0, which gives a deliberately bad frame.
module dht11_responder #(
  parameter int CLK_FREQ_HZ   = 100_000_000,
  parameter int START_MIN_US  = 10000,
  parameter int RESP_DELAY_US = 30,
  parameter int RESP_US       = 80,
  parameter int BIT_LOW_US    = 50,
  parameter int BIT0_HIGH_US  = 26,
  parameter int BIT1_HIGH_US  = 70
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] humidity,
  input  logic [15:0] temperature,
`ifdef DHT11_CKSUM_ERR_EN
  input  logic        i_corrupt_cksum,
`endif
  inout  wire         dhtio,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_err
);

  localparam int DIV   = CLK_FREQ_HZ / 1_000_000;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TMR_W = 16;

  localparam logic [DIV_W-1:0] DIV_LAST        = DIV_W'(DIV - 1);
  localparam logic [TMR_W-1:0] START_MIN_T     = TMR_W'(START_MIN_US);
  localparam logic [TMR_W-1:0] RESP_DELAY_LAST = TMR_W'(RESP_DELAY_US - 1);
  localparam logic [TMR_W-1:0] RESP_LAST       = TMR_W'(RESP_US - 1);
  localparam logic [TMR_W-1:0] BIT_LOW_LAST    = TMR_W'(BIT_LOW_US - 1);
  localparam logic [TMR_W-1:0] BIT0_LAST       = TMR_W'(BIT0_HIGH_US - 1);
  localparam logic [TMR_W-1:0] BIT1_LAST       = TMR_W'(BIT1_HIGH_US - 1);

  typedef enum logic [2:0] {
    IDLE, HOST_LOW, HOST_REL, RESP_LO, RESP_HI, BIT_LO, BIT_HI, END_LO
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q;
  logic             prev_q;
  logic [DIV_W-1:0] div_q;
  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] phase_last;
  logic [1:0]       settle_q;
  logic             low_tick_q;
  logic [5:0]       bit_cnt_q;
  logic [39:0]      frame_q;
  logic [7:0]       cksum;
  logic             line_s, fall, tick, phase_done;
  logic             high_phase, window, collision;
  logic             drive_low;

  assign line_s = sync_q[1];
  assign fall   = prev_q & ~line_s;
  assign tick   = (div_q == DIV_LAST);

  // The checksum is the 8-bit wrapping sum of the four data bytes.
  always_comb begin
    cksum = humidity[15:8] + humidity[7:0] + temperature[15:8] + temperature[7:0];
`ifdef DHT11_CKSUM_ERR_EN
    cksum = cksum ^ {7'd0, i_corrupt_cksum};
`endif
  end

  // Select the last tick of the current timed phase. The bit-high length follows the
  // bit that is being sent.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    phase_last = '0;
    case (state_q)
      HOST_REL:         phase_last = RESP_DELAY_LAST;
      RESP_LO, RESP_HI: phase_last = RESP_LAST;
      BIT_LO, END_LO:   phase_last = BIT_LOW_LAST;
      BIT_HI:           phase_last = frame_q[39] ? BIT1_LAST : BIT0_LAST;
      default:          phase_last = '0;
    endcase
  end

  assign phase_done = tick && (tmr_q == phase_last);

  // Collision watch. While the line is released, a second consecutive low tick sample
  // means someone else is holding the bus. The first two clocks after a release are
  // skipped because the synchronizer still shows our own low.
  assign high_phase = (state_q == RESP_HI) || (state_q == BIT_HI);
  assign window     = (settle_q == 2'd2);
  assign collision  = high_phase && window && tick && !line_s && low_tick_q;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (fall) state_d = HOST_LOW;
      HOST_LOW: if (line_s) state_d = (tmr_q >= START_MIN_T) ? HOST_REL : IDLE;
      HOST_REL: if (phase_done) state_d = RESP_LO;
      RESP_LO:  if (phase_done) state_d = RESP_HI;
      RESP_HI: begin
        if (collision)       state_d = IDLE;
        else if (phase_done) state_d = BIT_LO;
      end
      BIT_LO:   if (phase_done) state_d = BIT_HI;
      BIT_HI: begin
        if (collision)       state_d = IDLE;
        else if (phase_done) state_d = (bit_cnt_q == 6'd39) ? END_LO : BIT_LO;
      end
      END_LO:   if (phase_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments, so every always_ff reads the pre-edge values regardless of evaluation order.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Line synchronizer and falling-edge history. The line idles high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], dhtio};
      prev_q <= line_s;
    end
  end

  // Microsecond divider, phase timer, settle counter and collision run flag. All of
  // them restart on every state change, so each phase is a whole number of ticks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q      <= '0;
      tmr_q      <= '0;
      settle_q   <= '0;
      low_tick_q <= 1'b0;
    end else if (state_d != state_q) begin
      div_q      <= '0;
      tmr_q      <= '0;
      settle_q   <= '0;
      low_tick_q <= 1'b0;
    end else begin
      div_q <= tick ? '0 : div_q + DIV_W'(1);
      if (tick && (tmr_q != '1)) tmr_q <= tmr_q + TMR_W'(1);
      if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
      if (line_s)                             low_tick_q <= 1'b0;
      else if (tick && window && high_phase)  low_tick_q <= 1'b1;
    end
  end

  // Frame shift register and bit counter. The frame is latched once, at the accepted
  // start, so later input changes do not affect the frame in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_q   <= '0;
      bit_cnt_q <= '0;
    end else if ((state_q == HOST_LOW) && (state_d == HOST_REL)) begin
      frame_q   <= {humidity, temperature, cksum};
      bit_cnt_q <= '0;
    end else if ((state_q == BIT_HI) && (state_d == BIT_LO)) begin
      frame_q   <= {frame_q[38:0], 1'b0};
      bit_cnt_q <= bit_cnt_q + 6'd1;
    end
  end

  // Completion and collision pulses, each one clock long.
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_frame_done <= (state_q == END_LO) && (state_d == IDLE);
      o_err        <= collision;
    end
  end

  // Outputs decoded from the current state. The line is pulled low only in the driven
  // phases, and busy covers everything from the accepted start to the end of the frame.
  always_comb begin
    drive_low = 1'b0;
    o_busy    = 1'b1;
    case (state_q)
      IDLE, HOST_LOW:          o_busy    = 1'b0;
      RESP_LO, BIT_LO, END_LO: drive_low = 1'b1;
      default:                 drive_low = 1'b0;
    endcase
  end

  assign dhtio = drive_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder. The stimulus thread plays the host and queues the frame
// each start should produce. A monitor decodes the bus from pulse lengths whenever
// busy rises and checks the result against the queued expectation.
// Timing is scaled: 3 clocks per microsecond and a 200 us minimum start. A 300 us host
// low stands in for the 18 ms start, and a 100 us host low stands in for the 5 ms one.
`timescale 1ns/1ps
module tb_dht11_responder;
  localparam int CLK_HZ    = 3_000_000;
  localparam int CPU       = 3;
  localparam int START_MIN = 200;
  localparam int TOL       = 3;

  typedef enum {EV_FRAME, EV_COLL, EV_RESET} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [39:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] humidity = '0;
  logic [15:0] temperature = '0;
`ifdef DHT11_CKSUM_ERR_EN
  logic        corrupt = 1'b0;
`endif
  logic        host_low = 1'b0;
  logic        o_busy, o_frame_done, o_err;
  wire         dhtio;

  pullup (dhtio);
  assign dhtio = host_low ? 1'b0 : 1'bz;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   handled = 0;
  int   n_exp = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   busy_rises = 0;

  dht11_responder #(.CLK_FREQ_HZ(CLK_HZ), .START_MIN_US(START_MIN)) dut (
    .clk(clk),
    .rst(rst),
    .humidity(humidity),
    .temperature(temperature),
`ifdef DHT11_CKSUM_ERR_EN
    .i_corrupt_cksum(corrupt),
`endif
    .dhtio(dhtio),
    .o_busy(o_busy),
    .o_frame_done(o_frame_done),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    n_checks++;
    if (v < lo || v > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d clocks, expected %0d..%0d", name, v, lo, hi);
    end
  endtask

  // Reference model: the bytes as given, followed by their sum modulo 256.
  function automatic logic [39:0] model_frame(input logic [15:0] h, input logic [15:0] t,
                                              input bit bad);
    int          sum;
    logic [7:0]  ck;
    sum = int'(h[15:8]) + int'(h[7:0]) + int'(t[15:8]) + int'(t[7:0]);
    ck  = 8'(sum % 256);
    if (bad) ck = ck ^ 8'h01;
    return {h, t, ck};
  endfunction

  // Count the negedge samples for which the line stays at lvl. Returns -1 if busy drops
  // or the bound runs out first.
  task automatic measure(input logic lvl, input int max_clk, output int len);
    len = 0;
    while (dhtio === lvl) begin
      if (!o_busy || len >= max_clk) begin
        len = -1;
        return;
      end
      len++;
      @(negedge clk);
    end
  endtask

  task automatic handle_frame(input logic [39:0] exp);
    int          len, d0, e0, bad_lo, bad_hi;
    logic [39:0] got;
    d0 = done_cnt;
    e0 = err_cnt;
    measure(1'b1, 200*CPU, len);
    check_range("resp_delay", len, 30*CPU - TOL, 30*CPU + TOL);
    measure(1'b0, 200*CPU, len);
    check_range("resp_lo", len, 80*CPU - TOL, 80*CPU + TOL);
    measure(1'b1, 200*CPU, len);
    check_range("resp_hi", len, 80*CPU - TOL, 80*CPU + TOL);
    bad_lo = 0;
    bad_hi = 0;
    got = '0;
    for (int i = 0; i < 40; i++) begin
      measure(1'b0, 200*CPU, len);
      if (len < 50*CPU - TOL || len > 50*CPU + TOL) bad_lo++;
      measure(1'b1, 200*CPU, len);
      if (!((len >= 26*CPU - TOL && len <= 26*CPU + TOL) ||
            (len >= 70*CPU - TOL && len <= 70*CPU + TOL))) bad_hi++;
      got = {got[38:0], (len > 48*CPU)};
    end
    check("bit_lo_timing_errors", 64'(bad_lo), 64'(0));
    check("bit_hi_timing_errors", 64'(bad_hi), 64'(0));
    check("frame_data", 64'(got), 64'(exp));
    measure(1'b0, 200*CPU, len);
    check_range("end_lo", len, 50*CPU - TOL, 50*CPU + TOL);
    repeat (3) @(negedge clk);
    check("frame_done_pulses", 64'(done_cnt - d0), 64'(1));
    check("frame_err_pulses", 64'(err_cnt - e0), 64'(0));
    check("busy_after_frame", 64'(o_busy), 64'(0));
  endtask

  task automatic handle_abort(input bit expect_err);
    int d0, e0, n;
    d0 = done_cnt;
    e0 = err_cnt;
    n = 0;
    while (o_busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("abort_busy_dropped", 64'(o_busy), 64'(0));
    repeat (3) @(negedge clk);
    check("abort_err_pulses", 64'(err_cnt - e0), 64'(expect_err));
    check("abort_no_frame_done", 64'(done_cnt - d0), 64'(0));
  endtask

  // Pulse counters.
  initial forever begin
    @(negedge clk);
    if (o_frame_done === 1'b1) done_cnt++;
    if (o_err === 1'b1) err_cnt++;
  end

  // Monitor: every accepted start consumes one expectation from the scoreboard.
  initial begin
    logic busy_prev;
    exp_t e;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (o_busy === 1'b1 && !busy_prev) begin
        busy_rises++;
        check("expectation_queued", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          case (e.kind)
            EV_FRAME: handle_frame(e.data);
            EV_COLL:  handle_abort(1'b1);
            default:  handle_abort(1'b0);
          endcase
        end
        handled++;
      end
      busy_prev = o_busy;
    end
  end

  task automatic host_start(input int us);
    host_low = 1'b1;
    repeat (us*CPU) @(negedge clk);
    host_low = 1'b0;
  endtask

  task automatic wait_handled(input string name);
    int n;
    n = 0;
    while (handled < n_exp && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(handled >= n_exp), 64'(1));
    repeat (30) @(negedge clk);
  endtask

  task automatic push(input ev_kind_t k, input logic [39:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
    n_exp++;
  endtask

  // Wait for n falling edges on the line, then for the line to go high again.
  task automatic wait_lows(input int n, output bit ok);
    int   seen, t;
    logic prev;
    seen = 0;
    t = 0;
    prev = dhtio;
    while (seen < n && t < 20000) begin
      @(negedge clk);
      t++;
      if (prev === 1'b1 && dhtio === 1'b0) seen++;
      prev = dhtio;
    end
    while (dhtio !== 1'b1 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    ok = (seen == n) && (dhtio === 1'b1);
  endtask

  task automatic run_frame(input logic [15:0] h, input logic [15:0] t, input bit bad,
                           input bit mutate, input string name);
    int n;
    humidity = h;
    temperature = t;
`ifdef DHT11_CKSUM_ERR_EN
    corrupt = bad;
`endif
    push(EV_FRAME, model_frame(h, t, bad));
    host_start(300);
    if (mutate) begin
      n = 0;
      while (o_busy !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      repeat (700) @(negedge clk);
      humidity = 16'($urandom);
      temperature = 16'($urandom);
    end
    wait_handled(name);
  endtask

  // Global time limit.
  initial begin
    repeat (98000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish within the cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  r0, lows;
    bit  ok;

    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_busy", 64'(o_busy), 64'(0));
    check("reset_frame_done", 64'(o_frame_done), 64'(0));
    check("reset_err", 64'(o_err), 64'(0));
    check("reset_line_released", 64'(dhtio === 1'b1), 64'(1));
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // Nominal frame: 3C 00 19 05 5A.
    run_frame(16'h3C00, 16'h1905, 1'b0, 1'b0, "nominal_frame_seen");

    // A start shorter than the minimum gets no response.
    r0 = busy_rises;
    host_start(100);
    lows = 0;
    repeat (200*CPU) begin
      @(negedge clk);
      if (dhtio !== 1'b1) lows++;
    end
    check("short_start_no_busy", 64'(busy_rises - r0), 64'(0));
    check("short_start_line_idle", 64'(lows), 64'(0));

    // Reset during bit 12: the line is released on the next clock.
    humidity = 16'h1234;
    temperature = 16'h5678;
    push(EV_RESET, '0);
    host_start(300);
    wait_lows(14, ok);
    check("reset_scenario_reached_bit12", 64'(ok), 64'(1));
    repeat (20) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_line_released", 64'(dhtio === 1'b1), 64'(1));
    check("midreset_busy", 64'(o_busy), 64'(0));
    check("midreset_done", 64'(o_frame_done), 64'(0));
    check("midreset_err", 64'(o_err), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    wait_handled("midreset_abort_seen");
    run_frame(16'h4A02, 16'h1B07, 1'b0, 1'b0, "post_reset_frame_seen");

    // Collision: the host holds the line low for 5 us in the high phase of bit 3.
    humidity = 16'hA55A;
    temperature = 16'h0F0F;
    push(EV_COLL, '0);
    host_start(300);
    wait_lows(5, ok);
    check("collision_reached_bit3", 64'(ok), 64'(1));
    repeat (10) @(negedge clk);
    host_low = 1'b1;
    repeat (5*CPU) @(negedge clk);
    host_low = 1'b0;
    repeat (5) @(negedge clk);
    check("collision_line_released", 64'(dhtio === 1'b1), 64'(1));
    wait_handled("collision_abort_seen");

    // Checksum wrap: FF+80+80+01 gives 00.
    run_frame(16'hFF80, 16'h8001, 1'b0, 1'b0, "wrap_frame_seen");

    // Random data, with the inputs changed while the frame is being sent.
    run_frame(16'($urandom), 16'($urandom), 1'b0, 1'b1, "random_frame_seen");

`ifdef DHT11_CKSUM_ERR_EN
    // Corrupted checksum: 5A becomes 5B.
    run_frame(16'h3C00, 16'h1905, 1'b1, 1'b0, "corrupt_frame_seen");
`endif

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
